// File: rtl/pipe_pkg.sv
// Shared stage-payload layouts and entry tags for the inter-stage pipeline registers.
package pipe_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [4:0]  rd;
    logic [7:0]  ctrl;
  } id_ex_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] alu_res;
    logic [31:0] store_data;
    logic [4:0]  rd;
    logic [3:0]  ctrl;
  } ex_mem_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] wb_data;
    logic [4:0]  rd;
    logic        wb_en;
  } mem_wb_t;

  localparam int unsigned IF_ID_W  = $bits(if_id_t);
  localparam int unsigned ID_EX_W  = $bits(id_ex_t);
  localparam int unsigned EX_MEM_W = $bits(ex_mem_t);
  localparam int unsigned MEM_WB_W = $bits(mem_wb_t);

  localparam int unsigned WORD_W = 32;

  // Valid/QED tag of one held entry; the stage keeps the payload beside it so DATA_W stays free.
  typedef struct packed {
    logic valid;
    logic qed;
  } entry_tag_t;

  typedef struct packed {
    logic              valid;
    logic              qed;
    logic [WORD_W-1:0] data;
  } entry_t;

endpackage

// File: rtl/sat_counter.sv
// Width-parametrised saturating up-counter with enable and asynchronous active-low clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         en,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_q <= cnt_q + W'(1);
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with a 2-entry skid buffer, flush, QED sideband
// clear and a saturating stall counter.
module pipe_stage_reg #(
  parameter int unsigned DATA_W     = 32,
  parameter bit          CLEAR_DATA = 1'b1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              outside_reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_qed_vld,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_qed_vld,
  output logic [CNT_W-1:0]  stall_cnt
);

  import pipe_pkg::*;

  entry_tag_t        main_tag_q, main_tag_d, skid_tag_q, skid_tag_d, in_tag;
  logic [DATA_W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic              in_ready_q;
  logic              push, pop, stall_en;

  assign in_ready    = in_ready_q;
  assign out_valid   = main_tag_q.valid;
  assign out_data    = main_data_q;
  assign out_qed_vld = main_tag_q.valid & main_tag_q.qed;

  assign push     = in_valid & in_ready_q;
  assign pop      = main_tag_q.valid & out_ready;
  assign stall_en = main_tag_q.valid & ~out_ready;

  always_comb begin
    main_tag_d  = main_tag_q;
    skid_tag_d  = skid_tag_q;
    main_data_d = main_data_q;
    skid_data_d = skid_data_q;
    in_tag      = '{valid: 1'b1, qed: in_qed_vld};

    if (flush) begin
      main_tag_d.valid = 1'b0;
      skid_tag_d.valid = 1'b0;
      if (CLEAR_DATA) begin
        main_data_d = '0;
        skid_data_d = '0;
      end
    end else begin
      case ({main_tag_q.valid, skid_tag_q.valid})
        2'b00: begin
          if (push) begin
            main_tag_d  = in_tag;
            main_data_d = in_data;
          end
        end
        2'b10: begin
          if (push && pop) begin
            main_tag_d  = in_tag;
            main_data_d = in_data;
          end else if (push) begin
            skid_tag_d  = in_tag;
            skid_data_d = in_data;
          end else if (pop) begin
            main_tag_d.valid = 1'b0;
          end
        end
        2'b11: begin
          if (pop) begin
            main_tag_d       = skid_tag_q;
            main_data_d      = skid_data_q;
            skid_tag_d.valid = 1'b0;
          end
        end
        default: begin
          // Unreachable skid-only state: promote the skid entry so nothing is lost.
          main_tag_d       = skid_tag_q;
          main_data_d      = skid_data_q;
          skid_tag_d.valid = 1'b0;
        end
      endcase
    end

    // Applied last so an entry pushed in the same cycle also lands with qed=0.
    if (outside_reset) begin
      main_tag_d.qed = 1'b0;
      skid_tag_d.qed = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_tag_q <= '0;
      skid_tag_q <= '0;
      in_ready_q <= 1'b1;
    end else begin
      main_tag_q <= main_tag_d;
      skid_tag_q <= skid_tag_d;
      in_ready_q <= ~skid_tag_d.valid;
    end
  end

  if (CLEAR_DATA) begin : g_data_rst
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        main_data_q <= '0;
        skid_data_q <= '0;
      end else begin
        main_data_q <= main_data_d;
        skid_data_q <= skid_data_d;
      end
    end
  end else begin : g_data_norst
    always_ff @(posedge clk) begin
      main_data_q <= main_data_d;
      skid_data_q <= skid_data_d;
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_stall_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (stall_en),
    .cnt     (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: a capacity-2 FIFO model predicts handshakes, payload
// order, QED tags and the stall count under directed and random traffic.
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W    = 32;
  localparam int unsigned CNT_W     = 4;
  localparam int          STALL_MAX = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n, outside_reset, flush;
  logic              in_valid, in_ready, in_qed_vld;
  logic              out_valid, out_ready, out_qed_vld;
  logic [DATA_W-1:0] in_data, out_data;
  logic [CNT_W-1:0]  stall_cnt;

  always #5 clk = ~clk;

  pipe_stage_reg #(
    .DATA_W     (DATA_W),
    .CLEAR_DATA (1'b1),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .outside_reset (outside_reset),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_qed_vld    (in_qed_vld),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_qed_vld   (out_qed_vld),
    .stall_cnt     (stall_cnt)
  );

  typedef struct {
    logic [31:0] data;
    logic        qed;
  } exp_t;

  exp_t sb[$];
  int   exp_stall   = 0;
  bit   zero_exp    = 1'b1;
  int   occ_at_edge = 0;
  int   n_cmp       = 0;
  int   n_fail      = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a FIFO of capacity 2 whose occupancy seen at the edge gates acceptance.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sb.delete();
      exp_stall = 0;
      zero_exp  = 1'b1;
    end else begin
      if (occ_at_edge > 0 && !out_ready && exp_stall < STALL_MAX) exp_stall++;
      if (flush) begin
        sb.delete();
        zero_exp = 1'b1;
      end else if (in_valid && occ_at_edge < 2) begin
        sb.push_back('{in_data, in_qed_vld});
        zero_exp = 1'b0;
      end
      if (outside_reset) foreach (sb[i]) sb[i].qed = 1'b0;
    end
  end

  // Monitor: compares outputs mid-cycle and retires the head on each handshake.
  always @(negedge clk) begin
    if (!reset_n) begin
      occ_at_edge = 0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_qed", 32'(out_qed_vld), 32'd0);
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
    end else begin
      occ_at_edge = sb.size();
      check("in_ready", 32'(in_ready), 32'(sb.size() < 2));
      check("out_valid", 32'(out_valid), 32'(sb.size() > 0));
      check("stall_cnt", 32'(stall_cnt), 32'(exp_stall));
      if (sb.size() > 0) begin
        check("out_qed_vld", 32'(out_qed_vld), 32'(sb[0].qed));
        if (out_ready) begin
          check("out_data", out_data, sb[0].data);
          void'(sb.pop_front());
        end
      end else begin
        check("idle_qed", 32'(out_qed_vld), 32'd0);
        if (zero_exp) check("cleared_data", out_data, 32'd0);
      end
    end
  end

  task automatic drive(input logic v, input logic [31:0] d, input logic q, input logic rdy,
                       input logic fl, input logic orst);
    in_valid      = v;
    in_data       = d;
    in_qed_vld    = q;
    out_ready     = rdy;
    flush         = fl;
    outside_reset = orst;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input logic rdy, input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 32'h0, 1'b0, rdy, 1'b0, 1'b0);
  endtask

  initial begin
    bit done;

    // Reset then back-to-back streaming.
    reset_n = 1'b0;
    idle(1'b1, 2);
    reset_n = 1'b1;
    drive(1'b1, 32'h11, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h22, 1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 32'h33, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(1'b1, 3);

    // Back-pressure fill; 0xC is held upstream until the stage has room.
    drive(1'b1, 32'hA, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hB, 1'b0, 1'b0, 1'b0, 1'b0);
    check("full_in_ready", 32'(in_ready), 32'd0);
    for (int i = 0; i < 3; i++) drive(1'b1, 32'hC, 1'b0, 1'b0, 1'b0, 1'b0);
    done = 1'b0;
    for (int i = 0; i < 20 && !done; i++) begin
      done = in_ready;
      drive(1'b1, 32'hC, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    check("c_accepted", 32'(done), 32'd1);
    idle(1'b1, 3);

    // Flush while full with a simultaneous push.
    drive(1'b1, 32'h1, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h2, 1'b0, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'hD, 1'b0, 1'b0, 1'b1, 1'b0);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_in_ready", 32'(in_ready), 32'd1);
    check("flush_out_data", out_data, 32'd0);
    idle(1'b1, 2);

    // QED sideband cleared while the entry is held.
    drive(1'b1, 32'h44, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 1);
    check("qed_before", 32'(out_qed_vld), 32'd1);
    drive(1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("qed_after", 32'(out_qed_vld), 32'd0);
    check("qed_keep_valid", 32'(out_valid), 32'd1);
    check("qed_keep_data", out_data, 32'h44);
    idle(1'b1, 2);

    // Mid-cycle asynchronous reset while full with stall_cnt at 5.
    reset_n = 1'b0;
    idle(1'b1, 1);
    reset_n = 1'b1;
    drive(1'b1, 32'h51, 1'b1, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 32'h52, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 20 && exp_stall < 5; i++) idle(1'b0, 1);
    check("pre_rst_stall", 32'(stall_cnt), 32'd5);
    check("pre_rst_full", 32'(in_ready), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_stall_cnt", 32'(stall_cnt), 32'd0);
    check("async_qed", 32'(out_qed_vld), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 reset_n = 1'b1;
    idle(1'b1, 1);

    // Stall counter saturation.
    drive(1'b1, 32'h66, 1'b0, 1'b0, 1'b0, 1'b0);
    idle(1'b0, 20);
    check("sat_stall_cnt", 32'(stall_cnt), 32'(STALL_MAX));
    idle(1'b1, 2);

    // Random traffic with occasional flush and sideband clears.
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 15) == 0));
    end
    idle(1'b1, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, back-pressure-capable pipeline stage register, the successor to the fixed-field inter-stage latches (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries an opaque payload of DATA_W bits and a QED valid sideband under a valid/ready handshake, with flush support.
- A 2-entry skid buffer keeps full throughput and registers in_ready.
- A saturating stall counter supports performance and QED checking.

Parameters:
- DATA_W, 32, payload width in bits; the caller packs pc, operands, control and imm fields.
- CLEAR_DATA, 1, 1 = payload registers zeroed on reset and flush; 0 = only valid bits cleared.
- CNT_W, 16, stall counter width.

Ports:
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- outside_reset  in  1  synchronous active-high clear of the QED sideband only
- flush  in  1  synchronous discard of all held entries
- in_valid  in  1  upstream entry valid
- in_ready  out  1  stage can accept an entry
- in_data  in  DATA_W  upstream payload
- in_qed_vld  in  1  QED valid tag of the incoming entry
- out_valid  out  1  head entry valid
- out_ready  in  1  downstream accepts the head entry
- out_data  out  DATA_W  head payload
- out_qed_vld  out  1  QED tag of the head entry; 0 when out_valid=0
- stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main entry (the head, driving out_*) and skid entry. Each entry holds {valid, qed, data}.
- State is encoded by the valid bits:
  - EMPTY: main=0, skid=0.
  - ONE: main=1, skid=0.
  - FULL: main=1, skid=1.
  - The combination main=0, skid=1 is illegal.
- in_ready = !skid.valid, taken straight from a register with no combinational path from out_ready.
- Push = in_valid && in_ready. Pop = out_valid && out_ready.
- Transitions:
  - EMPTY, push: data goes to main → ONE.
  - ONE, push and pop: main is replaced by in_data → ONE.
  - ONE, push only: data goes to skid → FULL.
  - ONE, pop only → EMPTY.
  - FULL, pop: skid moves to main → ONE. No push is possible because in_ready=0.
  - FULL, no pop: hold.
- Latency: 1 cycle from push to out_valid. Throughput is 1 entry/cycle while out_ready=1.
- Payload is captured in full on every write. No field is retained from a previous entry.
- Order is strictly FIFO. No entry is ever dropped or duplicated, except by flush.
- flush:
  - Both valid bits go to 0 next cycle → EMPTY.
  - A push in the same cycle is discarded. Flush takes priority over push and pop.
  - Data is zeroed if CLEAR_DATA=1.
  - The stall counter is not affected.
- outside_reset:
  - Clears the qed bit of both entries next cycle.
  - A push in the same cycle stores qed=0.
  - Valid bits and data are unaffected.
- reset_n=0, asynchronous, takes effect mid-operation, with these values:
  - All valid bits 0.
  - qed bits 0.
  - Data 0 when CLEAR_DATA=1.
  - stall_cnt 0.
  - in_ready therefore 1 and out_valid 0.
- stall_cnt:
  - +1 on each cycle with out_valid && !out_ready.
  - Saturates at 2^CNT_W-1.
  - Cleared only by reset_n.
- out_data is don't-care when out_valid=0, but must be 0 when CLEAR_DATA=1 after reset or flush.

Decomposition:
- Shared package pipe_pkg:
  - Payload width constants (IF_ID_W, ID_EX_W, EX_MEM_W, MEM_WB_W).
  - Packed-struct typedefs for each stage payload.
  - Entry typedef {valid, qed, data}.
- Sub-module sat_counter (width-parametrised saturating incrementer with enable) for stall_cnt. The skid logic stays inline.

Test Plan:
1. Reset, then streaming:
   - Stimulus: reset_n low for 2 cycles, then push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1.
   - Response: during reset in_ready=1 and out_valid=0. Outputs 0x11, 0x22, 0x33 on cycles +1, +2, +3; in_ready never drops.
2. Back-pressure fill:
   - Stimulus: out_ready=0, push 0xA, then 0xB.
   - Response: FULL and in_ready=0 after the 2nd push. A 3rd in_valid with 0xC is not accepted and is held upstream.
   - Then out_ready=1: outputs 0xA, then 0xB, then 0xC is accepted; stall_cnt equals the number of stalled cycles.
3. Flush in FULL with simultaneous push:
   - Stimulus: assert flush in FULL with in_valid=1 and data 0xD.
   - Response: next cycle out_valid=0, in_ready=1, out_data=0. 0xD never appears.
4. QED sideband:
   - Stimulus: push with in_qed_vld=1, then assert outside_reset while the entry is held.
   - Response: out_qed_vld falls to 0 while out_valid and out_data are unchanged.
5. Mid-operation reset:
   - Stimulus: reset_n low asynchronously, mid-cycle, while in FULL with stall_cnt=5.
   - Response: immediately out_valid=0, stall_cnt=0, out_qed_vld=0.
6. Saturation:
   - Stimulus: CNT_W=4, hold out_valid=1 and out_ready=0 for 20 cycles.
   - Response: stall_cnt stops at 15.
